tictactoe_game_ctrl: RTL and testbench
======================================

// Module: tictactoe_game_ctrl
// PURPOSE
//  Game sequencer for the 3x3 tic-tac-toe VGA board. Debounces the nine active-low cell
//  buttons once per frame, validates each move, and alternates players. Detects a win or
//  a draw, and holds the board state that the display block renders.
//  Board updates are committed only while vnotactive is high, so a visible frame never tears.
// PARAMETERS
//  DEBOUNCE_FRAMES  2  consecutive identical frame samples required before the debounced button vector changes (1..15)
// PORTS
//  CLK            in   1   system clock; the block's only clock
//  RST            in   1   synchronous, active-high reset
//  board_but      in   9   raw cell buttons, active-low; bit i = cell (r,c), i = 3*r+c
//  vnotactive     in   1   high during vertical blanking
//  board          out  18  cell i at [2i+1:2i]: 00 empty, 01 player0 (black ring), 10 player1 (red ring); 11 never driven
//  player         out  1   player to move next (0/1)
//  move_cnt       out  4   moves placed in the current game, 0..9
//  winner         out  2   00 none, 01 player0, 10 player1, 11 draw
//  game_over      out  1   high while the FSM is in S_OVER
//  move_pulse     out  1   one-cycle pulse when a move is written
//  illegal_pulse  out  1   one-cycle pulse when a press is rejected
// BEHAVIOUR
//  Reset (RST=1 at posedge CLK): all outputs 0, board all-empty, FSM=S_RELEASE, debounce state cleared.
//  Frame tick: tick=1 for exactly one cycle when vnotactive=1 and the registered previous vnotactive=0.
//  Debounce, on tick only:
//   - raw = ~board_but.
//   - If raw == last_sample, stable_cnt increments, saturating at DEBOUNCE_FRAMES. Otherwise stable_cnt=1 and last_sample=raw.
//   - When stable_cnt reaches DEBOUNCE_FRAMES, btn_db <= last_sample.
//   - btn_db changes only on a tick cycle.
//  FSM (all transitions evaluated each CLK):
//   S_RELEASE: btn_db==0 -> S_ARMED. Every new move requires all buttons released first.
//   S_ARMED:
//    - btn_db one-hot and cell empty -> S_PLACE.
//    - btn_db one-hot and cell occupied -> illegal_pulse, -> S_RELEASE.
//    - two or more bits set -> illegal_pulse, -> S_RELEASE.
//    - btn_db==0 -> stay.
//   S_PLACE (1 cycle): board[cell] <= player?10:01; move_cnt++; mover <= player;
//    player <= ~player; move_pulse=1 -> S_CHECK.
//   S_CHECK (1 cycle): test the 8 lines (3 rows, 3 cols, 2 diagonals) for three equal mover codes.
//    - win -> winner <= mover+1, -> S_OVER.
//    - else if move_cnt==9 -> winner <= 11, -> S_OVER.
//    - else -> S_RELEASE. A win on move 9 reports the win, not a draw.
//   S_OVER: board frozen, presses never pulse illegal_pulse. Internal flag rel is set once btn_db==0.
//    When rel=1 and btn_db is one-hot, a new game starts:
//    board <= 0, player <= 0, move_cnt <= 0, winner <= 0, -> S_RELEASE.
//    That press does not place a stone.
//  Latency: a stable press reaches btn_db within DEBOUNCE_FRAMES ticks of its first sample.
//   board then updates 2 CLK after btn_db becomes one-hot (ARMED->PLACE, write at the PLACE edge).
//   winner/game_over follow 1 CLK after that.
//  The write in S_PLACE lands during blanking: the tick opens blanking, and a blanking interval
//   far exceeds 3 CLK.
//  Widths: move_cnt 4-bit, never exceeds 9. stable_cnt 4-bit, saturating.
//  Reset mid-game or in S_OVER returns to the reset state on the next edge, with no partial write.
//  A glitch shorter than DEBOUNCE_FRAMES frames never alters btn_db.
// TESTING
//  1 Reset: RST=1 for 2 CLK -> board=0, player=0, move_cnt=0, winner=00, game_over=0, all pulses 0.
//  2 Legal move, DEBOUNCE_FRAMES=2: hold board_but[4]=0 across 2 ticks -> board[9:8]=01, player=1,
//    move_cnt=1, one move_pulse. Release, then press cell 0 -> board[1:0]=10.
//  3 Illegal moves:
//    - re-press occupied cell 4 -> illegal_pulse, board unchanged.
//    - press cells 1 and 2 together -> illegal_pulse, no write.
//    - 1-frame glitch on cell 3 -> no btn_db change.
//  4 Win: player0 on cells 0,1,2, player1 on 3,4 -> winner=01 and game_over=1 one CLK after the third write.
//    Further presses leave board unchanged.
//  5 Draw: sequence 0,1,2,4,3,5,7,6,8 -> move_cnt=9, winner=11.
//    Alternate sequence 0,1,3,4,6 -> winner=01 (column win) at move 5.
//  6 Restart/reset: in S_OVER, release, then press any cell -> board=0, winner=00, player=0.
//    RST asserted while btn_db is one-hot in S_ARMED -> no write occurs.

Source files
------------

// File: rtl/tictactoe_game_ctrl_if.sv
// Bundles the button/blanking inputs and the game-state outputs of the tic-tac-toe sequencer.
//   board_but     : raw active-low cell buttons, bit i = cell 3*r+c
//   vnotactive    : high during vertical blanking
//   board         : cell i at [2i+1:2i], 00 empty, 01 player0, 10 player1
//   player        : player to move next
//   move_cnt      : moves placed in the current game (0..9)
//   winner        : 00 none, 01 player0, 10 player1, 11 draw
//   game_over     : high while the game is finished
//   move_pulse    : one-cycle pulse per stone written
//   illegal_pulse : one-cycle pulse per rejected press
interface tictactoe_game_ctrl_if;
    logic [8:0]  board_but;
    logic        vnotactive;
    logic [17:0] board;
    logic        player;
    logic [3:0]  move_cnt;
    logic [1:0]  winner;
    logic        game_over;
    logic        move_pulse;
    logic        illegal_pulse;

    modport master (
        output board_but, vnotactive,
        input  board, player, move_cnt, winner, game_over, move_pulse, illegal_pulse
    );

    modport slave (
        input  board_but, vnotactive,
        output board, player, move_cnt, winner, game_over, move_pulse, illegal_pulse
    );
endinterface

// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe game sequencer: per-frame button debounce, move validation, player
// alternation, win/draw detection and the board state rendered by the display.
//   CLK  : system clock
//   RST  : synchronous active-high reset
//   gif  : slave side of tictactoe_game_ctrl_if (buttons, blanking, game outputs)
module tictactoe_game_ctrl #(
    parameter int unsigned DEBOUNCE_FRAMES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    tictactoe_game_ctrl_if.slave  gif
);

    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_FRAMES);

    typedef enum logic [2:0] {
        S_RELEASE,
        S_ARMED,
        S_PLACE,
        S_CHECK,
        S_OVER
    } state_t;

    state_t            state_q;
    logic              vn_q;
    logic [8:0]        last_sample_q, last_sample_d;
    logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic [8:0]        btn_db_q, btn_db_d;
    logic [17:0]       board_q;
    logic              player_q;
    logic              mover_q;
    logic [3:0]        move_cnt_q;
    logic [1:0]        winner_q;
    logic              game_over_q;
    logic              move_pulse_q;
    logic              illegal_pulse_q;
    logic              rel_q;
    logic [3:0]        cell_q;

    logic              tick_c;
    logic [8:0]        raw_c;
    logic              btn_none_c;
    logic              btn_onehot_c;
    logic [3:0]        cell_c;
    logic [8:0]        occupied_c;
    logic              cell_taken_c;
    logic [1:0]        mover_code_c;
    logic              win_c;

    assign tick_c       = gif.vnotactive & ~vn_q;
    assign raw_c        = ~gif.board_but;
    assign btn_none_c   = (btn_db_q == 9'd0);
    assign btn_onehot_c = $onehot(btn_db_q);
    assign mover_code_c = {mover_q, ~mover_q};

    // Debounce: sample once per frame, publish after DEBOUNCE_FRAMES identical samples
    always_comb begin
        last_sample_d = last_sample_q;
        stable_cnt_d  = stable_cnt_q;
        btn_db_d      = btn_db_q;
        if (tick_c) begin
            if (raw_c == last_sample_q) begin
                if (stable_cnt_q < DB_MAX) begin
                    stable_cnt_d = stable_cnt_q + CNT_W'(1);
                end
            end else begin
                last_sample_d = raw_c;
                stable_cnt_d  = CNT_W'(1);
            end
            if (stable_cnt_d == DB_MAX) begin
                btn_db_d = last_sample_d;
            end
        end
    end

    // Pressed-cell index and per-cell occupancy
    always_comb begin
        cell_c     = 4'd0;
        occupied_c = 9'd0;
        for (int i = 0; i < 9; i++) begin
            if (btn_db_q[i]) begin
                cell_c = 4'(i);
            end
            occupied_c[i] = |board_q[2*i +: 2];
        end
    end
    assign cell_taken_c = |(btn_db_q & occupied_c);

    function automatic logic line_match(input logic [17:0] b, input logic [1:0] code,
                                        input int a, input int m, input int c);
        return (b[2*a +: 2] == code) && (b[2*m +: 2] == code) && (b[2*c +: 2] == code);
    endfunction

    // Three rows, three columns, two diagonals for the player who just moved
    assign win_c = line_match(board_q, mover_code_c, 0, 1, 2) |
                   line_match(board_q, mover_code_c, 3, 4, 5) |
                   line_match(board_q, mover_code_c, 6, 7, 8) |
                   line_match(board_q, mover_code_c, 0, 3, 6) |
                   line_match(board_q, mover_code_c, 1, 4, 7) |
                   line_match(board_q, mover_code_c, 2, 5, 8) |
                   line_match(board_q, mover_code_c, 0, 4, 8) |
                   line_match(board_q, mover_code_c, 2, 4, 6);

    // Game sequencer and all registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= S_RELEASE;
            vn_q            <= 1'b0;
            last_sample_q   <= 9'd0;
            stable_cnt_q    <= '0;
            btn_db_q        <= 9'd0;
            board_q         <= 18'd0;
            player_q        <= 1'b0;
            mover_q         <= 1'b0;
            move_cnt_q      <= 4'd0;
            winner_q        <= 2'b00;
            game_over_q     <= 1'b0;
            move_pulse_q    <= 1'b0;
            illegal_pulse_q <= 1'b0;
            rel_q           <= 1'b0;
            cell_q          <= 4'd0;
        end else begin
            vn_q            <= gif.vnotactive;
            last_sample_q   <= last_sample_d;
            stable_cnt_q    <= stable_cnt_d;
            btn_db_q        <= btn_db_d;
            move_pulse_q    <= 1'b0;
            illegal_pulse_q <= 1'b0;
            case (state_q)
                S_RELEASE: begin
                    if (btn_none_c) begin
                        state_q <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (btn_onehot_c) begin
                        if (cell_taken_c) begin
                            illegal_pulse_q <= 1'b1;
                            state_q         <= S_RELEASE;
                        end else begin
                            cell_q  <= cell_c;
                            state_q <= S_PLACE;
                        end
                    end else if (!btn_none_c) begin
                        illegal_pulse_q <= 1'b1;
                        state_q         <= S_RELEASE;
                    end
                end
                S_PLACE: begin
                    board_q[{cell_q, 1'b0} +: 2] <= {player_q, ~player_q};
                    move_cnt_q   <= move_cnt_q + 4'd1;
                    mover_q      <= player_q;
                    player_q     <= ~player_q;
                    move_pulse_q <= 1'b1;
                    state_q      <= S_CHECK;
                end
                S_CHECK: begin
                    if (win_c) begin
                        winner_q    <= mover_code_c;
                        game_over_q <= 1'b1;
                        rel_q       <= 1'b0;
                        state_q     <= S_OVER;
                    end else if (move_cnt_q == 4'd9) begin
                        winner_q    <= 2'b11;
                        game_over_q <= 1'b1;
                        rel_q       <= 1'b0;
                        state_q     <= S_OVER;
                    end else begin
                        state_q <= S_RELEASE;
                    end
                end
                S_OVER: begin
                    // New game needs a full release first; the starting press places nothing
                    if (btn_none_c) begin
                        rel_q <= 1'b1;
                    end else if (rel_q && btn_onehot_c) begin
                        board_q     <= 18'd0;
                        player_q    <= 1'b0;
                        move_cnt_q  <= 4'd0;
                        winner_q    <= 2'b00;
                        game_over_q <= 1'b0;
                        rel_q       <= 1'b0;
                        state_q     <= S_RELEASE;
                    end
                end
                default: state_q <= S_RELEASE;
            endcase
        end
    end

    assign gif.board         = board_q;
    assign gif.player        = player_q;
    assign gif.move_cnt      = move_cnt_q;
    assign gif.winner        = winner_q;
    assign gif.game_over     = game_over_q;
    assign gif.move_pulse    = move_pulse_q;
    assign gif.illegal_pulse = illegal_pulse_q;

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Bench for tictactoe_game_ctrl: directed game scenarios plus random presses, checked
// against a cell-array game model through a pulse-driven scoreboard and per-press state checks.
module tb_tictactoe_game_ctrl;

    logic CLK = 1'b0;
    logic RST;

    tictactoe_game_ctrl_if gif();

    tictactoe_game_ctrl #(.DEBOUNCE_FRAMES(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .gif (gif.slave)
    );

    always #5 CLK = ~CLK;

    // Frame timing: 16 active cycles, 8 blanking cycles
    initial begin
        gif.vnotactive = 1'b0;
        forever begin
            repeat (16) @(negedge CLK);
            gif.vnotactive = 1'b1;
            repeat (8) @(negedge CLK);
            gif.vnotactive = 1'b0;
        end
    end

    typedef struct {
        logic [1:0]  kind;      // 2'b10 move, 2'b01 illegal
        logic [17:0] board;
        logic        player;
        logic [3:0]  cnt;
        logic [1:0]  winner;
        logic        over;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    int cells[9];
    int m_player;
    int m_moves;
    int m_winner;
    bit m_over;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(cells[i]);
        return b;
    endfunction

    function automatic int m_line_winner();
        for (int l = 0; l < 8; l++) begin
            if (cells[lines[l][0]] != 0 &&
                cells[lines[l][0]] == cells[lines[l][1]] &&
                cells[lines[l][1]] == cells[lines[l][2]])
                return cells[lines[l][0]];
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) cells[i] = 0;
        m_player = 0;
        m_moves  = 0;
        m_winner = 0;
        m_over   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".board"},     32'(gif.board),     32'(m_board()));
        chk({tag, ".player"},    32'(gif.player),    32'(m_player));
        chk({tag, ".move_cnt"},  32'(gif.move_cnt),  32'(m_moves));
        chk({tag, ".winner"},    32'(gif.winner),    32'(m_winner));
        chk({tag, ".game_over"}, 32'(gif.game_over), 32'(m_over));
    endtask

    // Model the press, queue the expected pulse, then drive it for 'hold' frame samples
    task automatic issue(input logic [8:0] mask, input int hold);
        exp_t e;
        int   idx;
        int   w;
        idx = 0;
        for (int i = 0; i < 9; i++) if (mask[i]) idx = i;
        if (hold >= 2) begin
            if (m_over) begin
                if ($countones(mask) == 1) model_reset();
            end else if ($countones(mask) >= 2 || cells[idx] != 0) begin
                e.kind = 2'b01; e.board = m_board(); e.player = 1'(m_player);
                e.cnt = 4'(m_moves); e.winner = 2'b00; e.over = 1'b0;
                exp_q.push_back(e);
            end else begin
                cells[idx] = m_player + 1;
                m_moves++;
                m_player = 1 - m_player;
                w = m_line_winner();
                if (w != 0) begin
                    m_winner = w; m_over = 1'b1;
                end else if (m_moves == 9) begin
                    m_winner = 3; m_over = 1'b1;
                end
                e.kind = 2'b10; e.board = m_board(); e.player = 1'(m_player);
                e.cnt = 4'(m_moves); e.winner = 2'(m_winner); e.over = m_over;
                exp_q.push_back(e);
            end
        end
        @(negedge gif.vnotactive);
        gif.board_but = ~mask;
        repeat (hold) @(negedge gif.vnotactive);
        gif.board_but = 9'h1FF;
        repeat (3) @(negedge gif.vnotactive);
        check_state("after_press");
    endtask

    // Reset lands in the window between btn_db going one-hot and the write
    task automatic reset_while_armed(input logic [8:0] mask);
        @(negedge gif.vnotactive);
        gif.board_but = ~mask;
        @(negedge gif.vnotactive);
        @(posedge gif.vnotactive);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        gif.board_but = 9'h1FF;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        check_state("reset_armed");
        repeat (3) @(negedge gif.vnotactive);
        check_state("reset_armed_later");
    endtask

    // Scoreboard monitor: pop one expectation per pulse, then check the outcome a cycle later
    exp_t cur;
    bit   pend = 1'b0;
    always @(negedge CLK) begin
        if (!RST) begin
            if (pend) begin
                chk("sb.winner",    32'(gif.winner),    32'(cur.winner));
                chk("sb.game_over", 32'(gif.game_over), 32'(cur.over));
                pend = 1'b0;
            end
            if (gif.move_pulse || gif.illegal_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("sb.unexpected_pulse", {30'd0, gif.move_pulse, gif.illegal_pulse}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("sb.kind",     {30'd0, gif.move_pulse, gif.illegal_pulse}, 32'(cur.kind));
                    chk("sb.board",    32'(gif.board),    32'(cur.board));
                    chk("sb.player",   32'(gif.player),   32'(cur.player));
                    chk("sb.move_cnt", 32'(gif.move_cnt), 32'(cur.cnt));
                    if (cur.kind == 2'b10) pend = 1'b1;
                end
            end
        end
    end

    initial begin
        int r;
        int a;
        int b;
        model_reset();
        gif.board_but = 9'h1FF;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_state("reset");
        chk("reset.move_pulse",    32'(gif.move_pulse),    32'd0);
        chk("reset.illegal_pulse", 32'(gif.illegal_pulse), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge gif.vnotactive);

        issue(9'h010, 3);             // cell 4 by player0
        issue(9'h001, 2);             // cell 0 by player1
        issue(9'h010, 2);             // occupied
        issue(9'h006, 2);             // two cells together
        issue(9'h008, 1);             // one-frame glitch
        reset_while_armed(9'h020);

        foreach (lines[i]) ;          // keep table in scope
        issue(9'h001, 2); issue(9'h008, 2); issue(9'h002, 2);
        issue(9'h010, 2); issue(9'h004, 2);   // row 0 win for player0
        issue(9'h0C0, 2);             // multi-press while over: frozen, no pulse
        issue(9'h020, 2);             // restart
        check_state("restart1");

        issue(9'h001, 2); issue(9'h002, 2); issue(9'h004, 2);
        issue(9'h010, 2); issue(9'h008, 2); issue(9'h020, 2);
        issue(9'h080, 2); issue(9'h040, 2); issue(9'h100, 3);   // draw
        chk("draw.winner", 32'(gif.winner), 32'd3);
        issue(9'h080, 2);             // restart

        issue(9'h001, 2); issue(9'h002, 2); issue(9'h008, 2);
        issue(9'h010, 2); issue(9'h040, 2);   // column 0 win at move 5
        chk("colwin.winner", 32'(gif.winner), 32'd1);
        issue(9'h100, 2);             // restart

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 8);
            if (r < 8) begin
                issue(9'(1 << a), $urandom_range(2, 3));
            end else if (r == 8) begin
                b = (a + $urandom_range(1, 8)) % 9;
                issue(9'((1 << a) | (1 << b)), 2);
            end else begin
                issue(9'(1 << a), 1);
            end
        end

        repeat (20) @(negedge CLK);
        chk("sb.drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
